uart8_receiver: RTL and testbench

//   8-bit UART receiver: 1 start bit, 8 data bits LSB-first, 1 stop bit, optional even parity.

---
 rtl/uart8_receiver.sv | 191 +++++++++++++++++++
 tb/tb_uart8_receiver.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart8_receiver.sv
// ============================================================================
// Module   : uart8_receiver
// Summary  : 8N1 UART receiver with 2-flop line synchroniser and centre
//            sampling; optional even-parity bit via `UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart8_receiver #(
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in,
    output logic [7:0] out,
    output logic       valid,
    output logic       busy,
    output logic       err
);

    localparam logic [CNT_W-1:0] C_HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] C_FULL_M1 = CNT_W'(OVERSAMPLE - 1);
    localparam logic [2:0]       C_LAST_BIT = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       r_shreg;
    logic [7:0]       w_shreg_nxt;
    logic [7:0]       r_out;
    logic [7:0]       w_out_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             w_frame_ok;

`ifdef UART_RX_PARITY_EN
    logic             r_par;
    logic             w_par_nxt;

    // Even parity: data XOR parity bit must be zero for a good frame.
    assign w_frame_ok = r_sync2 & ~(^{r_shreg, r_par});
`else
    assign w_frame_ok = r_sync2;
`endif

    // Line synchroniser; flops reset to the idle (high) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shreg   <= 8'h00;
            r_out     <= 8'h00;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shreg   <= w_shreg_nxt;
            r_out     <= w_out_nxt;
            r_valid   <= w_valid_nxt;
            r_err     <= w_err_nxt;
`ifdef UART_RX_PARITY_EN
            r_par     <= w_par_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shreg_nxt = r_shreg;
        w_out_nxt   = r_out;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                if (en && !r_sync2) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end
            end
            S_START: begin
                // Half-bit recheck rejects short glitches on the idle line.
                if (r_cnt == C_HALF_M1) begin
                    w_cnt_nxt = '0;
                    if (!r_sync2) begin
                        w_state_nxt = S_DATA;
                        w_bit_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (r_cnt == C_FULL_M1) begin
                    w_shreg_nxt[r_bit_idx] = r_sync2;
                    w_cnt_nxt              = '0;
                    if (r_bit_idx == C_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == C_FULL_M1) begin
                    w_par_nxt   = r_sync2;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is caught.
                if (r_cnt == C_FULL_M1) begin
                    if (w_frame_ok) begin
                        w_out_nxt   = r_shreg;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_bit_nxt   = 3'd0;
            end
        endcase
    end

    assign out   = r_out;
    assign valid = r_valid;
    assign err   = r_err;
    assign busy  = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart8_receiver.sv
// ============================================================================
// Module   : tb_uart8_receiver
// Summary  : Directed self-checking bench for uart8_receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart8_receiver;

`ifdef UART_RX_PARITY_EN
    localparam int C_LAT = 171;
`else
    localparam int C_LAT = 155;
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic       line;
    logic [7:0] out;
    logic       valid;
    logic       busy;
    logic       err;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int vcnt      = 0;
    int ecnt      = 0;
    int bcnt      = 0;
    int last_vcyc = 0;
    int run       = 0;
    int max_run   = 0;
    int pulse_bad = 0;
    int t0        = 0;
    int v0, e0, b0;
    logic prev_valid = 1'b0;
    logic prev_err   = 1'b0;

    uart8_receiver #(.OVERSAMPLE(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .in    (line),
        .out   (out),
        .valid (valid),
        .busy  (busy),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Pulse/busy monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (valid) begin
            vcnt      = vcnt + 1;
            last_vcyc = cyc;
        end
        if (err) ecnt = ecnt + 1;
        if (valid && err) pulse_bad = pulse_bad + 1;
        if (valid && prev_valid) pulse_bad = pulse_bad + 1;
        if (err && prev_err) pulse_bad = pulse_bad + 1;
        prev_valid = valid;
        prev_err   = err;
        if (busy) begin
            bcnt = bcnt + 1;
            run  = run + 1;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input logic par, input logic drop_en);
        t0   = cyc;
        line = 1'b0;
        tick(16);
        if (drop_en) en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            line = d[i];
            tick(16);
        end
`ifdef UART_RX_PARITY_EN
        line = par;
        tick(16);
`else
        if (par === 1'bx) line = 1'b1;
`endif
        line = stop;
        tick(16);
        line = 1'b1;
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        line = 1'b1;
        tick(4);
        chk("reset_out",   {24'd0, out}, 32'h00);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_busy",  {31'd0, busy}, 32'd0);
        chk("reset_err",   {31'd0, err}, 32'd0);
        rst = 1'b0;
        en  = 1'b1;
        tick(10);

        // Nominal byte with latency check.
        v0 = vcnt; e0 = ecnt;
        send(8'hA5, 1'b1, 1'b0, 1'b0);
        chk("nom_valid_cnt", vcnt - v0, 1);
        chk("nom_latency",   last_vcyc - t0, C_LAT);
        chk("nom_out",       {24'd0, out}, 32'hA5);
        chk("nom_err_cnt",   ecnt - e0, 0);
        tick(4);
        chk("nom_busy_after", {31'd0, busy}, 32'd0);

        // Framing error: stop bit low.
        v0 = vcnt; e0 = ecnt;
        send(8'h3C, 1'b0, 1'b0, 1'b0);
        tick(30);
        chk("frm_err_cnt",   ecnt - e0, 1);
        chk("frm_valid_cnt", vcnt - v0, 0);
        chk("frm_out_kept",  {24'd0, out}, 32'hA5);

        // Start glitch of 4 cycles.
        v0 = vcnt; e0 = ecnt; max_run = 0;
        line = 1'b0;
        tick(4);
        line = 1'b1;
        tick(30);
        chk("gl_valid_cnt", vcnt - v0, 0);
        chk("gl_err_cnt",   ecnt - e0, 0);
        chk("gl_busy_run",  {31'd0, (max_run >= 1 && max_run <= 11)}, 32'd1);

        // Back-to-back frames with no idle gap.
        v0 = vcnt; e0 = ecnt;
        send(8'h00, 1'b1, 1'b0, 1'b0);
        chk("b2b_out0",    {24'd0, out}, 32'h00);
        chk("b2b_valid0",  vcnt - v0, 1);
        send(8'hFF, 1'b1, 1'b0, 1'b0);
        chk("b2b_latency1", last_vcyc - t0, C_LAT);
        chk("b2b_valid1",  vcnt - v0, 2);
        chk("b2b_out1",    {24'd0, out}, 32'hFF);
        chk("b2b_err",     ecnt - e0, 0);
        tick(10);

        // Reset during data bit 4 of 0x55.
        v0 = vcnt; e0 = ecnt;
        line = 1'b0;
        tick(16);
        for (int i = 0; i < 4; i++) begin
            line = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick(16);
        end
        line = 1'b1;
        tick(8);
        rst = 1'b1;
        tick(1);
        chk("rstmid_out",   {24'd0, out}, 32'h00);
        chk("rstmid_valid", {31'd0, valid}, 32'd0);
        chk("rstmid_busy",  {31'd0, busy}, 32'd0);
        chk("rstmid_err",   {31'd0, err}, 32'd0);
        rst = 1'b0;
        tick(40);
        chk("rstmid_no_pulse", (vcnt - v0) + (ecnt - e0), 0);
        send(8'h81, 1'b1, 1'b0, 1'b0);
        chk("after_rst_valid", vcnt - v0, 1);
        chk("after_rst_out",   {24'd0, out}, 32'h81);
        tick(10);

        // en dropped after start: frame still completes.
        v0 = vcnt;
        send(8'hC3, 1'b1, 1'b0, 1'b1);
        chk("endrop_valid", vcnt - v0, 1);
        chk("endrop_out",   {24'd0, out}, 32'hC3);
        tick(10);

        // en low for the whole frame: no response.
        v0 = vcnt; e0 = ecnt; b0 = bcnt;
        send(8'h5A, 1'b1, 1'b0, 1'b0);
        tick(20);
        chk("en0_valid", vcnt - v0, 0);
        chk("en0_err",   ecnt - e0, 0);
        chk("en0_busy",  bcnt - b0, 0);
        chk("en0_out",   {24'd0, out}, 32'hC3);
        en = 1'b1;
        tick(10);

`ifdef UART_RX_PARITY_EN
        v0 = vcnt; e0 = ecnt;
        send(8'h07, 1'b1, 1'b1, 1'b0);
        chk("par_ok_valid", vcnt - v0, 1);
        chk("par_ok_out",   {24'd0, out}, 32'h07);
        tick(10);
        v0 = vcnt; e0 = ecnt;
        send(8'h5E, 1'b1, 1'b0, 1'b0);
        chk("par_bad_err",   ecnt - e0, 1);
        chk("par_bad_valid", vcnt - v0, 0);
        chk("par_bad_out",   {24'd0, out}, 32'h07);
        tick(10);
`endif

        chk("pulse_shape", pulse_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
